layer_feeder: RTL and testbench
===============================

LAYER_FEEDER -- requirements
Module: layer_feeder

Interface
REQ-001 Parameter NEURONS, default 4: neurons per layer, time-multiplexed onto one downstream Neuron; legal range 2..16.
REQ-002 Parameter WIDTH, default 16: signed Q8.8 data/weight width.
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low; asserted when 0, sampled on the rising edge of clock.
REQ-005 in_valid/in_ready  input/output  1/1  input-vector handshake.
REQ-006 in_data_0, in_data_1  input  WIDTH each  signed input vector.
REQ-007 w_we  input  1  weight write strobe.
REQ-008 w_addr  input  clog2(NEURONS)  target neuron index.
REQ-009 w_data_0, w_data_1  input  WIDTH each  signed weight pair.
REQ-010 nrn_in_0, nrn_in_1, nrn_w_0, nrn_w_1  output  WIDTH each  operands to the Neuron.
REQ-011 nrn_out  input  WIDTH  combinational Neuron result (0x0000 or 0x0100).
REQ-012 out_valid/out_ready  output/input  1/1  result handshake.
REQ-013 out_spikes  output  NEURONS  bit i = neuron i fired.
REQ-014 out_count  output  clog2(NEURONS+1)  popcount of out_spikes.
REQ-015 w_err  output  1  sticky: weight write attempted while busy.

Function
REQ-016 FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-017 in_ready SHALL be 1 exactly when state==IDLE and reset is deasserted.
REQ-018 IDLE: on in_valid&&in_ready, latch in_data_0/1, clear idx to 0, go RUN.
REQ-019 RUN: each cycle drive nrn_in_0/1 = latched inputs and nrn_w_0/1 = weight pair [idx]; capture out_spikes[idx] = (signed nrn_out > 0) on the edge; idx increments.
REQ-020 RUN to DONE on the edge where idx==NEURONS-1; exactly NEURONS RUN cycles per vector.
REQ-021 out_valid SHALL rise NEURONS cycles after the accepting edge; out_spikes/out_count stable while out_valid=1.
REQ-022 DONE: hold out_valid=1 until out_valid&&out_ready, then go IDLE; in_ready returns to 1 on the next cycle (no same-cycle bypass).
REQ-023 nrn_* outputs SHALL be 0 in IDLE and DONE.
REQ-024 out_count SHALL be registered with out_spikes (updated in the same edge as the last capture).
REQ-025 Weight write in IDLE or DONE with w_addr<NEURONS: pair stored on the edge; visible to the next vector.
REQ-026 w_we with w_addr>=NEURONS: ignored, no flag.
REQ-027 w_we during RUN: ignored, weights unchanged, w_err set to 1 and held until reset.
REQ-028 in_valid held high during RUN/DONE: not accepted; in_data changes then have no effect on current results.
REQ-029 out_spikes bits not yet captured for a new vector retain prior values but are not observable since out_valid=0.

Reset
REQ-030 While reset=0 at an edge: state IDLE, idx 0, all weights 0, latched inputs 0, out_spikes 0, out_count 0, out_valid 0, w_err 0, nrn_* 0.
REQ-031 Reset asserted mid-RUN or in DONE SHALL abort the vector; no out_valid for it.
REQ-032 First vector after reset SHALL be acceptable on the first edge with reset=1.

Verification
REQ-033 Weights n0=(0x0100,0x0100), n1=(0x0100,0), n2=(0,0), n3=(0xFF00,0); input (0x0100,0xFF00) -> out_spikes=4'b0010, out_count=1, out_valid 4 cycles after accept.
REQ-034 Same weights, input (0x0100,0x0100) -> n0 fires, n1 fires, n2 not, n3 not: out_spikes=4'b0011, out_count=2.
REQ-035 out_ready held 0 for 5 cycles in DONE -> out_valid and outputs stable, in_ready=0 throughout; release -> in_ready=1 next cycle.
REQ-036 w_we to addr 1 during 2nd RUN cycle -> w_err=1, result identical to REQ-033; w_err stays 1 until reset.
REQ-037 reset=0 during 3rd RUN cycle -> out_valid never asserts, all weights read 0: next vector (0x0100,0x0100) gives out_spikes=0, out_count=0.
REQ-038 Back-to-back vectors with out_ready=1 and in_valid=1 -> accept interval NEURONS+2 cycles, results per vector match model.

Source files
------------

// File: rtl/layer_feeder.sv
// rtl/layer_feeder.sv - time-multiplexes one input vector across NEURONS weight pairs on a single Neuron
// Collects one spike bit per neuron and presents the spike vector plus its popcount.
module layer_feeder #(
  parameter int NEURONS = 4,
  parameter int WIDTH   = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data_0,
  input  logic [WIDTH-1:0]             in_data_1,
  input  logic                         w_we,
  input  logic [$clog2(NEURONS)-1:0]   w_addr,
  input  logic [WIDTH-1:0]             w_data_0,
  input  logic [WIDTH-1:0]             w_data_1,
  output logic [WIDTH-1:0]             nrn_in_0,
  output logic [WIDTH-1:0]             nrn_in_1,
  output logic [WIDTH-1:0]             nrn_w_0,
  output logic [WIDTH-1:0]             nrn_w_1,
  input  logic [WIDTH-1:0]             nrn_out,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NEURONS-1:0]           out_spikes,
  output logic [$clog2(NEURONS+1)-1:0] out_count,
  output logic                         w_err
);

  localparam int AW = $clog2(NEURONS);
  localparam int CW = $clog2(NEURONS + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic [AW-1:0]      idx;
  logic [WIDTH-1:0]   in_lat_0, in_lat_1;
  logic [WIDTH-1:0]   w_mem_0 [NEURONS];
  logic [WIDTH-1:0]   w_mem_1 [NEURONS];
  logic [NEURONS-1:0] spikes_next;
  logic [CW-1:0]      count_next;
  logic               fire;
  logic               addr_ok;

  assign in_ready = (state == IDLE) && reset;
  assign addr_ok  = (32'(w_addr) < 32'(NEURONS));

  // Strictly positive in signed terms: sign bit clear and nonzero.
  assign fire = !nrn_out[WIDTH-1] && (nrn_out != '0);

  assign nrn_in_0 = (state == RUN) ? in_lat_0     : '0;
  assign nrn_in_1 = (state == RUN) ? in_lat_1     : '0;
  assign nrn_w_0  = (state == RUN) ? w_mem_0[idx] : '0;
  assign nrn_w_1  = (state == RUN) ? w_mem_1[idx] : '0;

  // Popcount includes the bit being captured this cycle so count lands with the last spike.
  always_comb begin
    spikes_next      = out_spikes;
    spikes_next[idx] = fire;
    count_next       = '0;
    for (int i = 0; i < NEURONS; i++) begin
      count_next = count_next + CW'(spikes_next[i]);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      idx        <= '0;
      in_lat_0   <= '0;
      in_lat_1   <= '0;
      out_spikes <= '0;
      out_count  <= '0;
      out_valid  <= 1'b0;
      w_err      <= 1'b0;
      for (int i = 0; i < NEURONS; i++) begin
        w_mem_0[i] <= '0;
        w_mem_1[i] <= '0;
      end
    end else begin
      if (w_we) begin
        if (state == RUN) begin
          w_err <= 1'b1;
        end else if (addr_ok) begin
          w_mem_0[w_addr] <= w_data_0;
          w_mem_1[w_addr] <= w_data_1;
        end
      end
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_lat_0 <= in_data_0;
            in_lat_1 <= in_data_1;
            idx      <= '0;
            state    <= RUN;
          end
        end
        RUN: begin
          out_spikes <= spikes_next;
          if (idx == AW'(NEURONS - 1)) begin
            out_count <= count_next;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + AW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_layer_feeder.sv
// tb/tb_layer_feeder.sv - self-checking bench for layer_feeder with an emulated Neuron
// Directed vectors then randomized back-to-back vectors against a per-neuron dot-product model.
module tb_layer_feeder;

  localparam int N = 4;
  localparam int W = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data_0 = '0, in_data_1 = '0;
  logic          w_we = 1'b0;
  logic [1:0]    w_addr = '0;
  logic [W-1:0]  w_data_0 = '0, w_data_1 = '0;
  logic [W-1:0]  nrn_in_0, nrn_in_1, nrn_w_0, nrn_w_1;
  logic [W-1:0]  nrn_out;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [N-1:0]  out_spikes;
  logic [2:0]    out_count;
  logic          w_err;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic signed [W-1:0] mw0 [N];
  logic signed [W-1:0] mw1 [N];

  layer_feeder #(.NEURONS(N), .WIDTH(W)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data_0(in_data_0), .in_data_1(in_data_1),
    .w_we(w_we), .w_addr(w_addr), .w_data_0(w_data_0), .w_data_1(w_data_1),
    .nrn_in_0(nrn_in_0), .nrn_in_1(nrn_in_1), .nrn_w_0(nrn_w_0), .nrn_w_1(nrn_w_1),
    .nrn_out(nrn_out),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_spikes(out_spikes), .out_count(out_count), .w_err(w_err)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [W-1:0] neuron(input logic signed [W-1:0] a0, a1, b0, b1);
    longint s;
    s = longint'(a0) * longint'(b0) + longint'(a1) * longint'(b1);
    return (s > 0) ? 16'h0100 : 16'h0000;
  endfunction

  assign nrn_out = neuron(nrn_in_0, nrn_in_1, nrn_w_0, nrn_w_1);

  function automatic logic [N-1:0] model(input logic signed [W-1:0] a0, a1);
    logic [N-1:0] r;
    longint s;
    for (int i = 0; i < N; i++) begin
      s = longint'(a0) * longint'(mw0[i]) + longint'(a1) * longint'(mw1[i]);
      r[i] = (s > 0);
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic write_w(input int a, input logic [W-1:0] d0, input logic [W-1:0] d1);
    w_addr = 2'(a); w_data_0 = d0; w_data_1 = d1; w_we = 1'b1;
    @(posedge clock); #1 w_we = 1'b0;
    if (a < N) begin
      mw0[a] = d0;
      mw1[a] = d1;
    end
  endtask

  task automatic wait_out(inout int lat);
    while (!out_valid && lat < 20) begin
      @(posedge clock); #1;
      lat++;
    end
  endtask

  task automatic run_vec(input string tag, input logic [W-1:0] a0, input logic [W-1:0] a1,
                         input logic [N-1:0] exp_sp, input int hold, input bit dwrite);
    int n = 0;
    int lat = 0;
    while (!in_ready && n < 30) begin
      @(posedge clock); #1;
      n++;
    end
    in_data_0 = a0; in_data_1 = a1; in_valid = 1'b1;
    @(posedge clock); #1 in_valid = 1'b0;
    wait_out(lat);
    chk({tag, "_latency"}, lat, N);
    chk({tag, "_spikes"}, out_spikes, exp_sp);
    chk({tag, "_count"}, out_count, $countones(exp_sp));
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'b1; in_data_0 = 16'($urandom); in_data_1 = 16'($urandom);
      if (dwrite && k == 0) begin
        w_we = 1'b1; w_addr = 2'd2; w_data_0 = 16'h0100; w_data_1 = 16'h0000;
      end
      @(posedge clock); #1;
      if (dwrite && k == 0) begin
        w_we = 1'b0; mw0[2] = 16'h0100; mw1[2] = 16'h0000;
      end
      chk({tag, "_hold_valid"}, out_valid, 1);
      chk({tag, "_hold_spikes"}, out_spikes, exp_sp);
      chk({tag, "_hold_count"}, out_count, $countones(exp_sp));
      chk({tag, "_hold_ready"}, in_ready, 0);
      chk({tag, "_hold_nrn"}, {nrn_in_0, nrn_w_1}, 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clock); #1 out_ready = 1'b0;
    chk({tag, "_rel_valid"}, out_valid, 0);
    chk({tag, "_rel_ready"}, in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int n;
    int prev;
    logic [N-1:0] exp_sp;
    bit saw_valid;

    for (int i = 0; i < N; i++) begin
      mw0[i] = '0;
      mw1[i] = '0;
    end
    repeat (2) @(posedge clock);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_spikes", out_spikes, 0);
    chk("rst_count", out_count, 0);
    chk("rst_w_err", w_err, 0);
    chk("rst_nrn", {nrn_in_0, nrn_in_1, nrn_w_0, nrn_w_1}, 0);
    @(negedge clock);
    reset = 1'b1;
    #1 chk("first_ready", in_ready, 1);

    run_vec("zero_w", 16'h0100, 16'h0100, 4'b0000, 0, 1'b0);

    write_w(0, 16'h0100, 16'h0100);
    write_w(1, 16'h0100, 16'h0000);
    write_w(2, 16'h0000, 16'h0000);
    write_w(3, 16'hFF00, 16'h0000);
    run_vec("vec_a", 16'h0100, 16'hFF00, 4'b0010, 0, 1'b0);
    run_vec("vec_b", 16'h0100, 16'h0100, 4'b0011, 5, 1'b1);
    run_vec("done_wr", 16'h0100, 16'h0100, 4'b0111, 0, 1'b0);
    write_w(2, 16'h0000, 16'h0000);

    // Weight write attempted during the second RUN cycle.
    in_data_0 = 16'h0100; in_data_1 = 16'hFF00; in_valid = 1'b1;
    @(posedge clock); #1 in_valid = 1'b0;
    chk("run_nrn_in_0", nrn_in_0, 16'h0100);
    chk("run_nrn_in_1", nrn_in_1, 16'hFF00);
    chk("run_nrn_w_0", nrn_w_0, 16'h0100);
    @(posedge clock); #1;
    w_we = 1'b1; w_addr = 2'd1; w_data_0 = 16'hFF00; w_data_1 = 16'hFF00;
    @(posedge clock); #1 w_we = 1'b0;
    chk("werr_set", w_err, 1);
    lat = 2;
    wait_out(lat);
    chk("werr_latency", lat, N);
    chk("werr_spikes", out_spikes, 4'b0010);
    chk("werr_count", out_count, 1);
    out_ready = 1'b1;
    @(posedge clock); #1 out_ready = 1'b0;
    run_vec("werr_next", 16'h0100, 16'hFF00, 4'b0010, 0, 1'b0);
    chk("werr_sticky", w_err, 1);

    // Reset during the third RUN cycle aborts the vector.
    in_data_0 = 16'h0100; in_data_1 = 16'hFF00; in_valid = 1'b1;
    @(posedge clock); #1 in_valid = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1 reset = 1'b0;
    @(posedge clock); #1 reset = 1'b1;
    for (int i = 0; i < N; i++) begin
      mw0[i] = '0;
      mw1[i] = '0;
    end
    chk("abort_w_err", w_err, 0);
    saw_valid = 1'b0;
    repeat (N + 2) begin
      @(posedge clock); #1;
      if (out_valid) saw_valid = 1'b1;
    end
    chk("abort_no_valid", saw_valid, 0);
    run_vec("abort_next", 16'h0100, 16'h0100, 4'b0000, 0, 1'b0);

    // Randomized back-to-back vectors.
    for (int i = 0; i < N; i++) write_w(i, 16'($urandom), 16'($urandom));
    in_data_0 = 16'($urandom); in_data_1 = 16'($urandom);
    in_valid = 1'b1; out_ready = 1'b1;
    prev = 0;
    for (int v = 0; v < 8; v++) begin
      n = 0;
      while (!in_ready && n < 30) begin
        @(posedge clock); #1;
        n++;
      end
      if (v > 0) chk("b2b_interval", cyc - prev, N + 2);
      prev = cyc;
      exp_sp = model(in_data_0, in_data_1);
      @(posedge clock); #1;
      in_data_0 = 16'($urandom); in_data_1 = 16'($urandom);
      lat = 0;
      wait_out(lat);
      chk("b2b_latency", lat, N);
      chk("b2b_spikes", out_spikes, exp_sp);
      chk("b2b_count", out_count, $countones(exp_sp));
    end
    in_valid = 1'b0;
    @(posedge clock); #1 out_ready = 1'b0;
    chk("b2b_end_ready", in_ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
